// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_SAT = 4'h9;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional leading-zero digit blanking is built when LEADING_ZERO_BLANK_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one adjust+shift per cycle, BIN_W cycles
// DONE  | one-cycle result pulse; may accept a new start
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd_out,
  output logic                    overflow,
  output logic [DIGITS-1:0]       digit_en
);

  localparam int SCR_W = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t             state_q, state_nx;
  logic [BIN_W-1:0]   shift_q, shift_nx;
  logic [SCR_W-1:0]   scratch_q, scratch_nx, adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q, ovf_nx;
  logic               accept, shift_en, last;
  logic [SCR_W-1:0]   bcd_q;
  logic               ovf_out_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (scratch_q[g*BCD_W +: BCD_W]),
      .adjusted (adj[g*BCD_W +: BCD_W])
    );
  end

  // The bit falling off the top digit means the value no longer fits.
  assign scratch_nx = {adj[SCR_W-2:0], shift_q[BIN_W-1]};
  assign shift_nx   = shift_q << 1;
  assign ovf_nx     = ovf_q | adj[SCR_W-1];
  assign last       = (cnt_q == LAST_CNT);

  always_comb begin
    state_nx = state_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      if (accept) begin
        shift_q   <= bin_in;
        scratch_q <= '0;
        cnt_q     <= '0;
        ovf_q     <= 1'b0;
      end else if (shift_en) begin
        shift_q   <= shift_nx;
        scratch_q <= scratch_nx;
        cnt_q     <= cnt_q + CNT_W'(1);
        ovf_q     <= ovf_nx;
        if (last) begin
          bcd_q     <= ovf_nx ? {DIGITS{BCD_SAT}} : scratch_nx;
          ovf_out_q <= ovf_nx;
        end
      end
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign bcd_out  = bcd_q;
  assign overflow = ovf_out_q;

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] en_q, en_nx;
  logic              nz;

  // A digit is shown once it or any more significant digit is non-zero.
  always_comb begin
    en_nx = '0;
    nz    = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz       = nz | (scratch_nx[i*BCD_W +: BCD_W] != 4'h0);
      en_nx[i] = nz;
    end
    en_nx[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q <= DIGITS'(1);
    end else if (shift_en && last) begin
      en_q <= ovf_nx ? '1 : en_nx;
    end
  end

  assign digit_en = en_q;
`else
  assign digit_en = '1;
`endif

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised, iterative binary-to-BCD converter using shift-and-add-3 (double-dabble), one input bit per clock. Converts a BIN_W-bit unsigned value into DIGITS packed BCD digits with a start/done handshake, saturation on overflow and an optional leading-zero digit-enable mask. It sits between the distance/measurement datapath and the display drivers, replacing wide combinational divide/modulo chains with a small sequential engine.

## Interface
- BIN_W, 14: binary input width; must be ≥1.
- DIGITS, 4: number of BCD output digits; must be ≥1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous and active-low.
- start  in  1  conversion request; sampled only in IDLE or DONE.
- bin_in  in  BIN_W  unsigned value; captured on an accepted start.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse; result valid.
- bcd_out  out  4*DIGITS  packed BCD; digit 0 at [3:0]; held until the next done.
- overflow  out  1  result saturated; held with bcd_out.
- digit_en  out  DIGITS  per-digit display enable (see Configuration).

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE→SHIFT on start.
  - SHIFT→DONE after BIN_W iterations.
  - DONE→SHIFT if start, else DONE→IDLE.
- Accept: copy bin_in to shift register; clear BCD scratch (4*DIGITS bits), sticky overflow flag and iteration counter (width $clog2(BIN_W+1)).
- Each SHIFT cycle:
  - every scratch digit ≥5 gets +3;
  - {scratch, shift register} shifts left by 1.
  - Bit leaving the top of scratch sets sticky overflow.
- Final iteration: registered outputs load from the next-state scratch value on the same edge.
  - overflow=0: bcd_out = final scratch.
  - overflow=1: bcd_out = all digits 4'h9 and overflow=1.
- start during SHIFT is ignored. bin_in changes after accept have no effect.
- Reset values: state IDLE, busy 0, done 0, bcd_out 0, overflow 0, digit_en = only bit 0 set (macro on) / all ones (macro off).
- Reset asserted mid-conversion aborts: no done, outputs take reset values.

## Timing
- start high at edge k (state IDLE or DONE) → busy=1 for cycles after edges k..k+BIN_W-1.
- Last shift occurs at edge k+BIN_W. done=1, bcd_out/overflow/digit_en valid in the cycle after edge k+BIN_W.
- Latency is BIN_W cycles from accept to done.
- Back-to-back: start held high gives a done every BIN_W+1 cycles.
- done never asserts for two consecutive cycles.
- busy and done are never high together.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - digit_en[i]=1 iff digit i or any higher digit is non-zero; digit_en[0] is always 1.
  - digit_en is registered alongside bcd_out.
  - On overflow, digit_en is all ones.
- Macro undefined: digit_en is tied to all ones; no blanking logic is built. The port list is unchanged.

## Structure
- Package bin2bcd_pkg:
  - state typedef (IDLE, SHIFT, DONE);
  - BCD_W=4 constant;
  - BCD_SAT digit constant 4'h9.
- Sub-module bcd_digit_adj: 4-bit combinational add-3-if-≥5. One instance per digit, generated DIGITS times.
- Counter, FSM, sticky overflow and output registers live in bin2bcd_seq.

## Test plan
- rst_n low 2 cycles, start held high → bcd_out=0, overflow=0, done=0, busy=0, digit_en=4'b0001 (macro on).
- BIN_W=14, DIGITS=4, bin_in=9999, start one cycle → done exactly 14 cycles later, bcd_out=16'h9999, overflow=0, digit_en=4'b1111.
- bin_in=12345 → overflow=1, bcd_out=16'h9999; bin_in=0 → bcd_out=16'h0000, digit_en=4'b0001; bin_in=47 → bcd_out=16'h0047, digit_en=4'b0011 (macro off: 4'b1111).
- Convert 1234; pulse start with bin_in=42 during SHIFT → ignored, bcd_out=16'h1234. Start again in the DONE cycle with 42 → second done 15 cycles after the first, bcd_out=16'h0042.
- rst_n low for one cycle at the 5th SHIFT cycle of converting 8191 → no done; outputs reset. Then convert 8191 → bcd_out=16'h8191.
- BIN_W=8, DIGITS=3, bin_in=255 → done after 8 cycles, bcd_out=12'h255, overflow=0.
